task_2_debounce: RTL and testbench
==================================

Name: task_2_debounce

Overview:
Front-end stage for the LED on/off FSM. It conditions a raw, bouncing push-button input and produces a clean debounced level, single-cycle press and release pulses, and a press-toggled state on o_DATA. Its o_DATA[0] drives i_DATA[0] of the downstream LED stage directly. Cleanup and debouncing use a 4-state FSM with a stability counter.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-stable cycles required to accept a level change (legal range 1..65535)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width (derived; never overridden)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  reset; asynchronous, active-high
i_DATA  input  8  bit 0 = raw button (asynchronous to i_clk); bits 7:1 ignored
o_DATA  output  8  bit 0 = debounced level; bit 1 = press pulse; bit 2 = release pulse; bit 3 = toggle state; bits 7:4 = 0

Behaviour:
- Reset (i_rst=1, async assert, sync-style release on next edge): sync flops = 0, state = S_REL, counter = 0, o_DATA = 8'h00. Reset mid-bounce or mid-count aborts all activity and ignores any pending change.
- Synchronizer: i_DATA[0] -> q1 -> q2 (two flops). FSM sees only q2.
- States (one-hot):
  - S_REL: level 0. If q2=1 -> S_PWAIT, cnt<=1.
  - S_PWAIT: if q2=0 -> S_REL, cnt<=0, no pulse. Else if cnt==DEBOUNCE_CYCLES -> S_PRS, cnt<=0. Else cnt<=cnt+1.
  - S_PRS: level 1. If q2=0 -> S_RWAIT, cnt<=1.
  - S_RWAIT: if q2=1 -> S_PRS, cnt<=0, no pulse. Else if cnt==DEBOUNCE_CYCLES -> S_REL, cnt<=0. Else cnt<=cnt+1.
- Outputs are registered.
  - o_DATA[0] = 1 in S_PRS or S_RWAIT.
  - o_DATA[1] = 1 for exactly one cycle, on the cycle o_DATA[0] first reads 1 (S_PWAIT->S_PRS).
  - o_DATA[2] = 1 for exactly one cycle, on the cycle o_DATA[0] first reads 0 (S_RWAIT->S_REL).
  - o_DATA[3] inverts on every press pulse.
- Latency: count edges starting from the first edge that samples i_DATA[0]=1 (edge 1). o_DATA[0] and o_DATA[1] rise after edge DEBOUNCE_CYCLES+3, provided the input holds for the whole window. Release latency is symmetric.
- Glitch rejection: any q2 reversal during a WAIT state returns to the prior stable state with no output change. The counter restarts from 1 on the next change.
- Press and release pulses are mutually exclusive and never adjacent: at least DEBOUNCE_CYCLES+1 cycles separate them.
- Counter never exceeds DEBOUNCE_CYCLES. It holds 0 in stable states.
- Button held through reset release: q2 rises 2 edges after reset deasserts. The press debounces normally and a press pulse is issued.
- DEBOUNCE_CYCLES=1: an accepted change needs a 2-cycle stable q2. Latency is 4 edges.

Decomposition:
- Package task_2_pkg holds:
  - eDEB_state_t enum, one-hot 4-bit: S_REL=4'b0001, S_PWAIT=4'b0010, S_PRS=4'b0100, S_RWAIT=4'b1000.
  - Output bit-index constants: LVL=0, PRESS=1, REL=2, TGL=3.
- Sub-module sync_2ff (1-bit two-flop synchronizer, async active-high reset to 0), reused by later input stages.

Test Plan:
- Reset: i_rst=1 with i_DATA[0]=1 mid-count -> o_DATA=8'h00 immediately (async), state S_REL. After release, press debounces again from cnt=1.
- Clean press (DEBOUNCE_CYCLES=4): i_DATA[0] 0->1 held -> o_DATA[0] and o_DATA[1] rise after edge 7. o_DATA[1] is high exactly one cycle. o_DATA[3] becomes 1. o_DATA=8'h0B then 8'h09.
- Bounce: i_DATA[0] toggles 1,0,1,0 each cycle for 10 cycles, then stays 0 -> o_DATA stays 8'h00 throughout, no pulses.
- Release: from pressed, i_DATA[0] 1->0 held -> o_DATA[2] pulses once after edge 7. Level returns to 0. Toggle remains 1 (o_DATA=8'h0C then 8'h08).
- Two full press/release cycles -> exactly two press pulses, two release pulses. o_DATA[3] ends at 0. o_DATA[7:4]=0 at all times.
- Boundary: high pulse lasting exactly DEBOUNCE_CYCLES synchronized cycles (one short) -> rejected. Pulse lasting DEBOUNCE_CYCLES+1 -> accepted.

Source files
------------

// File: rtl/task_2_debounce_pkg.sv
// Shared types and constants for the push-button debounce stage.
// Contents:
//   eDEB_state_t : one-hot debounce FSM state
//   LVL/PRESS/REL/TGL : bit positions within o_DATA
package task_2_pkg;

    typedef enum logic [3:0] {
        S_REL   = 4'b0001,
        S_PWAIT = 4'b0010,
        S_PRS   = 4'b0100,
        S_RWAIT = 4'b1000
    } eDEB_state_t;

    localparam int LVL   = 0;
    localparam int PRESS = 1;
    localparam int REL   = 2;
    localparam int TGL   = 3;

endpackage

// File: rtl/task_2_debounce_if.sv
// Data bus between the button source and the debounce stage.
// Signals:
//   i_DATA [7:0] : bit 0 = raw button, other bits ignored
//   o_DATA [7:0] : debounced level / press / release / toggle, bits 7:4 zero
// Modports:
//   master : drives i_DATA, observes o_DATA
//   slave  : the debounce stage
interface task_2_debounce_if;

    logic [7:0] i_DATA;
    logic [7:0] o_DATA;

    modport master (output i_DATA, input o_DATA);
    modport slave  (input i_DATA, output o_DATA);

endinterface

// File: rtl/task_2_debounce_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
// Ports:
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset, clears both flops
//   i_d   : asynchronous input
//   o_q   : synchronized output, two edges behind i_d
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic q1;
    logic q2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= i_d;
            q2 <= q1;
        end
    end

    assign o_q = q2;

endmodule

// File: rtl/task_2_debounce.sv
// Push-button debounce front end: synchronizes the raw button, accepts a
// level change only after DEBOUNCE_CYCLES+1 consecutive stable samples, and
// produces registered level, press/release pulses and a press toggle.
// Ports:
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   bus   : slave side of task_2_debounce_if (i_DATA in, o_DATA out)
//
// state   | meaning
// --------+-------------------------------------------------
// S_REL   | stable released, level 0, counter held at 0
// S_PWAIT | q2 went high, counting stability toward press
// S_PRS   | stable pressed, level 1, counter held at 0
// S_RWAIT | q2 went low, counting stability toward release
import task_2_pkg::*;

module task_2_debounce #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    task_2_debounce_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES);

    eDEB_state_t      state;
    eDEB_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       data_q;
    logic [7:0]       data_nxt;
    logic             q2;
    logic [6:0]       unused_bits;

    assign unused_bits = bus.i_DATA[7:1];

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (bus.i_DATA[0]),
        .o_q   (q2)
    );

    // State, counter and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_REL;
            cnt    <= '0;
            data_q <= 8'h00;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

    // Next state and stability counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_REL: begin
                cnt_nxt = '0;
                if (q2) begin
                    state_nxt = S_PWAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_PWAIT: begin
                if (!q2) begin
                    state_nxt = S_REL;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TC) begin
                    state_nxt = S_PRS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_PRS: begin
                cnt_nxt = '0;
                if (!q2) begin
                    state_nxt = S_RWAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_RWAIT: begin
                if (q2) begin
                    state_nxt = S_PRS;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TC) begin
                    state_nxt = S_REL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_REL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming transition so that the registered
    // level and its pulse appear on the same cycle.
    always_comb begin
        data_nxt        = 8'h00;
        data_nxt[LVL]   = (state_nxt == S_PRS) || (state_nxt == S_RWAIT);
        data_nxt[PRESS] = (state == S_PWAIT) && (state_nxt == S_PRS);
        data_nxt[REL]   = (state == S_RWAIT) && (state_nxt == S_REL);
        data_nxt[TGL]   = data_q[TGL] ^ data_nxt[PRESS];
    end

    assign bus.o_DATA = data_q;

endmodule

// File: tb/tb_task_2_debounce.sv
module tb_task_2_debounce;

    localparam int D = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    task_2_debounce_if bus ();

    task_2_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_press = 0;
    int n_rel   = 0;

    // Reference: a change is accepted once the synchronized input has
    // disagreed with the accepted level for D+1 consecutive samples.
    bit       m_q1, m_q2, m_lvl, m_tgl;
    int       m_run;
    bit [7:0] m_exp;

    always @(posedge i_clk or posedge i_rst) begin
        bit pr, rl;
        if (i_rst) begin
            m_q1 = 0; m_q2 = 0; m_lvl = 0; m_tgl = 0; m_run = 0;
            m_exp = 8'h00;
        end else begin
            pr = 0; rl = 0;
            if (m_q2 != m_lvl) begin
                m_run = m_run + 1;
                if (m_run == D + 1) begin
                    m_lvl = m_q2;
                    m_run = 0;
                    if (m_lvl) pr = 1; else rl = 1;
                    m_tgl = m_tgl ^ pr;
                end
            end else begin
                m_run = 0;
            end
            m_q2 = m_q1;
            m_q1 = bus.i_DATA[0];
            m_exp = {4'b0000, m_tgl, rl, pr, m_lvl};
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive raw level, let one edge pass, compare against the model.
    task automatic tick(input bit raw);
        bus.i_DATA = {7'b1010101, raw};
        @(posedge i_clk);
        @(negedge i_clk);
        check("model", bus.o_DATA, m_exp);
        if (bus.o_DATA[1]) n_press++;
        if (bus.o_DATA[2]) n_rel++;
    endtask

    initial begin
        bit raw;
        int len;
        bus.i_DATA = 8'h00;
        repeat (3) @(negedge i_clk);
        check("reset_out", bus.o_DATA, 8'h00);
        i_rst = 1'b0;
        repeat (4) tick(0);
        check("idle", bus.o_DATA, 8'h00);

        // clean press
        for (int k = 1; k <= D + 4; k++) begin
            tick(1);
            if (k == D + 2) check("press_early", bus.o_DATA, 8'h00);
            if (k == D + 3) check("press_pulse", bus.o_DATA, 8'h0B);
            if (k == D + 4) check("press_hold", bus.o_DATA, 8'h09);
        end
        // clean release
        for (int k = 1; k <= D + 4; k++) begin
            tick(0);
            if (k == D + 2) check("rel_early", bus.o_DATA, 8'h09);
            if (k == D + 3) check("rel_pulse", bus.o_DATA, 8'h0C);
            if (k == D + 4) check("rel_hold", bus.o_DATA, 8'h08);
        end
        // bounce: nothing may change
        for (int k = 0; k < 10; k++) begin
            tick(k[0] == 1'b0);
            check("bounce", bus.o_DATA, 8'h08);
        end
        repeat (D + 4) tick(0);
        check("bounce_settle", bus.o_DATA, 8'h08);

        // second full press/release
        repeat (D + 4) tick(1);
        repeat (D + 4) tick(0);
        check("two_press", 8'(n_press), 8'd2);
        check("two_rel", 8'(n_rel), 8'd2);
        check("tgl_end", bus.o_DATA, 8'h00);

        // boundary: D samples high rejected, D+1 accepted
        repeat (D) tick(1);
        repeat (D + 4) tick(0);
        check("short_reject", bus.o_DATA, 8'h00);
        for (int k = 1; k <= D + 4; k++) begin
            tick(k <= D + 1);
            if (k == D + 3) check("exact_accept", bus.o_DATA, 8'h0B);
        end
        repeat (2 * D + 4) tick(0);
        check("after_accept", bus.o_DATA, 8'h08);

        // async reset mid-count, button held through release
        repeat (3) tick(1);
        #2 i_rst = 1'b1;
        #1 check("async_rst", bus.o_DATA, 8'h00);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 1; k <= D + 4; k++) begin
            tick(1);
            if (k == D + 2) check("rst_press_early", bus.o_DATA, 8'h00);
            if (k == D + 3) check("rst_press_pulse", bus.o_DATA, 8'h0B);
        end

        // random runs around the acceptance threshold
        raw = 1;
        for (int r = 0; r < 120; r++) begin
            raw = ~raw;
            len = $urandom_range(1, D + 4);
            repeat (len) tick(raw);
        end
        repeat (D + 4) tick(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
